// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF/ID instruction queue: datapath width,
// MIPS instruction field positions and the queue entry layout.
package if_id_queue_pkg;

    localparam int unsigned XLEN = 32;

    localparam int unsigned OPCODE_HI = 31;
    localparam int unsigned OPCODE_LO = 26;
    localparam int unsigned RS_HI     = 25;
    localparam int unsigned RS_LO     = 21;
    localparam int unsigned RT_HI     = 20;
    localparam int unsigned RT_LO     = 16;
    localparam int unsigned RD_HI     = 15;
    localparam int unsigned RD_LO     = 11;
    localparam int unsigned SHAMT_HI  = 10;
    localparam int unsigned SHAMT_LO  = 6;
    localparam int unsigned FUNCT_HI  = 5;
    localparam int unsigned FUNCT_LO  = 0;
    localparam int unsigned IMM_HI    = 15;
    localparam int unsigned IMM_LO    = 0;
    localparam int unsigned JIDX_HI   = 25;
    localparam int unsigned JIDX_LO   = 0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } entry_t;

endpackage

// File: rtl/instr_fields.sv
// MIPS field extraction on the queue head; every field reads as zero
// whenever no head entry is valid.
module instr_fields
    import if_id_queue_pkg::*;
(
    input  logic            valid,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] instr,
    output logic [5:0]      opcode,
    output logic [4:0]      rs,
    output logic [4:0]      rt,
    output logic [4:0]      rd,
    output logic [4:0]      shamt,
    output logic [5:0]      funct,
    output logic [XLEN-1:0] imm_sext,
    output logic [XLEN-1:0] jtarget
);

    logic [XLEN-1:0] pc_plus4;

    always_comb begin
        opcode   = '0;
        rs       = '0;
        rt       = '0;
        rd       = '0;
        shamt    = '0;
        funct    = '0;
        imm_sext = '0;
        jtarget  = '0;
        pc_plus4 = pc + 32'd4;
        if (valid) begin
            opcode   = instr[OPCODE_HI:OPCODE_LO];
            rs       = instr[RS_HI:RS_LO];
            rt       = instr[RT_HI:RT_LO];
            rd       = instr[RD_HI:RD_LO];
            shamt    = instr[SHAMT_HI:SHAMT_LO];
            funct    = instr[FUNCT_HI:FUNCT_LO];
            imm_sext = {{16{instr[IMM_HI]}}, instr[IMM_HI:IMM_LO]};
            // Region bits come from pc+4; the masked form keeps the whole sum live.
            jtarget  = (pc_plus4 & 32'hF000_0000) | {4'b0000, instr[JIDX_HI:JIDX_LO], 2'b00};
        end
    end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: circular buffer of {pc, instr} with flush,
// registered occupancy and combinational decode of the head entry.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_instr,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_instr,
    output logic [5:0]               opcode,
    output logic [4:0]               rs,
    output logic [4:0]               rt,
    output logic [4:0]               rd,
    output logic [4:0]               shamt,
    output logic [5:0]               funct,
    output logic [XLEN-1:0]          imm_sext,
    output logic [XLEN-1:0]          jtarget,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop;
    entry_t          head;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = count_q;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q].pc    = in_pc;
                mem_d[wr_ptr_q].instr = in_instr;
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_pc    = out_valid ? head.pc    : '0;
        out_instr = out_valid ? head.instr : '0;
    end

    instr_fields u_fields (
        .valid    (out_valid),
        .pc       (out_pc),
        .instr    (out_instr),
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd       (rd),
        .shamt    (shamt),
        .funct    (funct),
        .imm_sext (imm_sext),
        .jtarget  (jtarget)
    );

endmodule

// File: tb/tb_if_id_queue.sv
// Scoreboard bench for if_id_queue: a queue-based reference model tracks
// accepted entries; a negedge monitor compares outputs against its head.
module tb_if_id_queue;

    localparam int unsigned DEPTH = 4;

    logic        CLK = 1'b0;
    logic        RST, in_valid, flush, out_ready;
    logic [31:0] in_pc, in_instr;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr, imm_sext, jtarget;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [2:0]  count;

    always #5 CLK = ~CLK;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_sext(imm_sext), .jtarget(jtarget), .count(count)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Reference model: a bounded queue updated from the inputs seen at each edge.
    bit   m_pop, m_push;
    ent_t m_new;
    always @(posedge CLK) begin
        if (RST || flush) begin
            exp_q.delete();
        end else begin
            m_pop  = out_ready && (exp_q.size() != 0);
            m_push = in_valid && (exp_q.size() < DEPTH);
            m_new.pc    = in_pc;
            m_new.instr = in_instr;
            if (m_pop)  void'(exp_q.pop_front());
            if (m_push) exp_q.push_back(m_new);
        end
    end

    // Monitor: compares every output to the model head in mid-cycle.
    ent_t        h;
    logic [31:0] e_imm;
    always @(negedge CLK) begin
        if (!RST) begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("in_ready", 32'(in_ready), (exp_q.size() < DEPTH) ? 32'd1 : 32'd0);
            check("out_valid", 32'(out_valid), (exp_q.size() != 0) ? 32'd1 : 32'd0);
            if (exp_q.size() != 0) begin
                h = exp_q[0];
                e_imm = h.instr % 32'd65536;
                if (e_imm >= 32'd32768) e_imm = e_imm - 32'd65536;
                check("out_pc", out_pc, h.pc);
                check("out_instr", out_instr, h.instr);
                check("opcode", 32'(opcode), h.instr / 32'd67108864);
                check("rs", 32'(rs), (h.instr / 32'd2097152) % 32'd32);
                check("rt", 32'(rt), (h.instr / 32'd65536) % 32'd32);
                check("rd", 32'(rd), (h.instr / 32'd2048) % 32'd32);
                check("shamt", 32'(shamt), (h.instr / 32'd64) % 32'd32);
                check("funct", 32'(funct), h.instr % 32'd64);
                check("imm_sext", imm_sext, e_imm);
                check("jtarget", jtarget,
                      ((h.pc + 32'd4) & 32'hF000_0000) + (h.instr % 32'd67108864) * 32'd4);
            end else begin
                check("idle_pc", out_pc, 32'd0);
                check("idle_instr", out_instr, 32'd0);
                check("idle_fields", {opcode, rs, rt, rd, shamt, funct}, 32'd0);
                check("idle_imm", imm_sext, 32'd0);
                check("idle_jtarget", jtarget, 32'd0);
            end
        end
    end

    // One clock of stimulus; inputs return to idle right after the edge.
    task automatic cyc(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl, input logic rst);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        RST       = rst;
        @(posedge CLK);
        #2;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        RST       = 1'b0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] ins);
        cyc(1'b1, pc, ins, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid = 1'b0; in_pc = '0; in_instr = '0;
        out_ready = 1'b0; flush = 1'b0; RST = 1'b1;
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        @(negedge CLK);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_count", 32'(count), 32'd0);

        // R-type decode of add $8,$9,$10
        push(32'h0, 32'h012A_4020);
        @(negedge CLK);
        check("r_valid", 32'(out_valid), 32'd1);
        check("r_rs", 32'(rs), 32'd9);
        check("r_rt", 32'(rt), 32'd10);
        check("r_rd", 32'(rd), 32'd8);
        check("r_funct", 32'(funct), 32'h20);
        check("r_count", 32'(count), 32'd1);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Fill to full, fifth push refused, then drain in order
        for (int i = 0; i < 5; i++) push(32'(i * 4), $urandom);
        @(negedge CLK);
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("drain_pc", out_pc, 32'(i * 4));
            cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        end
        @(negedge CLK);
        check("drained_valid", 32'(out_valid), 32'd0);

        // Steady push+pop at count 2, wrapping the pointers
        push(32'h100, $urandom);
        push(32'h104, $urandom);
        for (int i = 0; i < 10; i++) cyc(1'b1, 32'(32'h108 + i * 4), $urandom, 1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        check("stream_count", 32'(count), 32'd2);
        check("stream_head", out_pc, 32'h128);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) push(32'(32'h200 + i * 4), $urandom);
        cyc(1'b1, 32'h300, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0);
        @(negedge CLK);
        check("flush_count", 32'(count), 32'd0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);

        // Sign extension and jump target
        push(32'h40, 32'h2108_FFFC);
        @(negedge CLK);
        check("imm_neg", imm_sext, 32'hFFFF_FFFC);
        check("imm_rt", 32'(rt), 32'd8);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);
        push(32'h0040_0000, 32'h0810_0004);
        @(negedge CLK);
        check("jtarget_dir", jtarget, 32'h0040_0010);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Reset overrides push and flush mid-stream
        for (int i = 0; i < 3; i++) push(32'(32'h500 + i * 4), $urandom);
        cyc(1'b1, 32'h600, 32'h1234_5678, 1'b1, 1'b1, 1'b1);
        @(negedge CLK);
        check("rst_mid_count", 32'(count), 32'd0);
        check("rst_mid_pc", out_pc, 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);
        push(32'h700, 32'hAAAA_5555);
        @(negedge CLK);
        check("post_rst_head", out_pc, 32'h700);
        cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
                1'($urandom_range(0, 99) < 50),
                1'($urandom_range(0, 99) < 4),
                1'($urandom_range(0, 99) < 2));
        end

        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
